// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multi-cycle multiply/divide unit.
// The EXE_* codes sit in the ALU's default branch, away from its existing codes.
package mul_div_unit_pkg;

  localparam logic [3:0] EXE_MULT  = 4'b1100;
  localparam logic [3:0] EXE_MULTU = 4'b1101;
  localparam logic [3:0] EXE_DIV   = 4'b1110;
  localparam logic [3:0] EXE_DIVU  = 4'b1111;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [3:0] cmd);
    op_dec_t d;
    d = '{is_mul: 1'b0, is_div: 1'b0, is_signed: 1'b0};
    case (cmd)
      EXE_MULT:  d = '{is_mul: 1'b1, is_div: 1'b0, is_signed: 1'b1};
      EXE_MULTU: d = '{is_mul: 1'b1, is_div: 1'b0, is_signed: 1'b0};
      EXE_DIV:   d = '{is_mul: 1'b0, is_div: 1'b1, is_signed: 1'b1};
      EXE_DIVU:  d = '{is_mul: 1'b0, is_div: 1'b1, is_signed: 1'b0};
      default:   d = '{is_mul: 1'b0, is_div: 1'b0, is_signed: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: magnitude shift-add / restoring divide,
// then a single sign-fix cycle that commits HI/LO together with a done pulse.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int COM_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [COM_SIZE-1:0] EXE_CMD,
  input  logic [SIZE-1:0]     val1,
  input  logic [SIZE-1:0]     val2,
  output logic                busy,
  output logic                done,
  output logic [SIZE-1:0]     hi,
  output logic [SIZE-1:0]     lo,
  output logic                div_by_zero
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic [2*SIZE-1:0] cneg(input logic [2*SIZE-1:0] x, input logic en);
    return en ? (~x + (2*SIZE)'(1)) : x;
  endfunction

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, dbz_q;
  logic [SIZE-1:0]   hi_q, lo_q;
  logic [SIZE-1:0]   mcand_q, dvsr_q;
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic              is_div_q, neg_q, neg_rem_q, zero_div_q;

  op_dec_t           dec;
  logic              accept;
  logic              zero_div;
  logic [SIZE-1:0]   mag1, mag2;
  logic [SIZE:0]     add_sum, trial, diff;
  logic [2*SIZE-1:0] prod_fix, quot_fix, rem_fix;

  // Command decode and operand magnitudes for the IDLE accept.
  always_comb begin
    dec      = decode_op(4'(EXE_CMD));
    accept   = start && (dec.is_mul || dec.is_div);
    zero_div = dec.is_div && (val2 == {SIZE{1'b0}});
    mag1     = SIZE'(cneg({{SIZE{1'b0}}, val1}, dec.is_signed && val1[SIZE-1]));
    mag2     = SIZE'(cneg({{SIZE{1'b0}}, val2}, dec.is_signed && val2[SIZE-1]));
  end

  // One iteration of the multiply or divide recurrence on the shared accumulator.
  always_comb begin
    add_sum = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, mcand_q} : (SIZE+1)'(0));
    trial   = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
    diff    = trial - {1'b0, dvsr_q};
    if (is_div_q) begin
      if (!diff[SIZE]) begin
        acc_d = {diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};
      end else begin
        acc_d = {trial[SIZE-1:0], acc_q[SIZE-2:0], 1'b0};
      end
    end else begin
      acc_d = {add_sum, acc_q[SIZE-1:1]};
    end
  end

  // Sign application used in FIX.
  always_comb begin
    prod_fix = cneg(acc_q, neg_q);
    quot_fix = cneg({{SIZE{1'b0}}, acc_q[SIZE-1:0]}, neg_q);
    rem_fix  = cneg({{SIZE{1'b0}}, acc_q[2*SIZE-1:SIZE]}, neg_rem_q);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      dvsr_q     <= '0;
      acc_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              mcand_q    <= mag1;
              dvsr_q     <= mag2;
              // A zero divisor keeps the raw dividend so FIX can return it as HI.
              acc_q      <= dec.is_div ? {{SIZE{1'b0}}, (zero_div ? val1 : mag1)}
                                       : {{SIZE{1'b0}}, mag2};
              is_div_q   <= dec.is_div;
              neg_q      <= dec.is_signed && (val1[SIZE-1] ^ val2[SIZE-1]);
              neg_rem_q  <= dec.is_signed && val1[SIZE-1];
              zero_div_q <= zero_div;
              cnt_q      <= '0;
              dbz_q      <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= zero_div ? ST_FIX : ST_CALC;
            end
          end
          ST_CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (zero_div_q) begin
              hi_q <= acc_q[SIZE-1:0];
              lo_q <= {SIZE{1'b1}};
            end else if (is_div_q) begin
              hi_q <= rem_fix[SIZE-1:0];
              lo_q <= quot_fix[SIZE-1:0];
            end else begin
              hi_q <= prod_fix[2*SIZE-1:SIZE];
              lo_q <= prod_fix[SIZE-1:0];
            end
            dbz_q   <= zero_div_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random ops
// checked against plain-arithmetic reference results.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int S = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [3:0]    EXE_CMD = 4'b0000;
  logic [S-1:0]  val1 = '0;
  logic [S-1:0]  val2 = '0;
  logic          busy, done, div_by_zero;
  logic [S-1:0]  hi, lo;

  mul_div_unit #(.SIZE(S), .COM_SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .EXE_CMD(EXE_CMD),
    .val1(val1), .val2(val2), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [S-1:0] hi;
    logic [S-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  int           nvec = 0;
  int           nerr = 0;
  logic [S-1:0] last_hi = '0;
  logic [S-1:0] last_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no done (cycle %0d)", hi, lo, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
      last_hi = hi;
      last_lo = lo;
    end
  end

  function automatic void model(input logic [3:0] cmd, input logic [S-1:0] a, input logic [S-1:0] b,
                                output logic [S-1:0] h, output logic [S-1:0] l, output logic d);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = 1'b0;
    h  = '0;
    l  = '0;
    if (cmd == EXE_MULT) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (cmd == EXE_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      h = a;
      l = '1;
      d = 1'b1;
    end else if (cmd == EXE_DIV) begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction

  task automatic issue(input logic [3:0] cmd, input logic [S-1:0] a, input logic [S-1:0] b,
                       input bit push, input bit now,
                       input logic [S-1:0] eh, input logic [S-1:0] el, input logic ed);
    bit dv;
    if (!now) @(negedge clk);
    start = 1'b1;
    EXE_CMD = cmd;
    val1 = a;
    val2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      dv = (cmd == EXE_DIV) || (cmd == EXE_DIVU);
      sb_q.push_back('{eh, el, ed, cyc + ((dv && b == '0) ? 1 : S + 1)});
      chk("dbz_cleared_on_accept", 64'(div_by_zero), 64'd0);
      chk("busy_after_accept", 64'(busy), 64'd1);
    end
  endtask

  task automatic wait_done(input int exp_busy);
    int nb = 0;
    int t  = 0;
    bit seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", t);
    end
    chk("busy_cycles", 64'(nb), 64'(exp_busy));
    chk("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [3:0] cmd, input logic [S-1:0] a, input logic [S-1:0] b, input bit now);
    logic [S-1:0] h, l;
    logic d;
    model(cmd, a, b, h, l, d);
    issue(cmd, a, b, 1'b1, now, h, l, d);
    wait_done(d ? 1 : S + 1);
  endtask

  initial begin
    logic [3:0] codes [4];
    codes[0] = EXE_MULT;
    codes[1] = EXE_MULTU;
    codes[2] = EXE_DIV;
    codes[3] = EXE_DIVU;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b1;

    issue(EXE_MULTU, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b0, 32'h1, 32'hFFFFFFFE, 1'b0);
    wait_done(33);
    issue(EXE_MULT, 32'hFFFFFFF9, 32'd6, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    wait_done(33);
    issue(EXE_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done(33);
    issue(EXE_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14, 1'b0);
    wait_done(33);
    issue(EXE_DIVU, 32'h1234, 32'd0, 1'b1, 1'b0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    wait_done(1);
    issue(EXE_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 32'h80000000, 1'b0);
    wait_done(33);

    // start raised again mid-CALC must not disturb the running multiply
    issue(EXE_MULTU, 32'd3, 32'd5, 1'b1, 1'b0, 32'd0, 32'd15, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    EXE_CMD = EXE_DIVU;
    val1 = 32'd9;
    val2 = 32'd2;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(26);

    // flush in CALC: back to IDLE, no done, result registers untouched
    issue(EXE_MULT, 32'd11, 32'd13, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(last_hi));
    chk("flush_lo", 64'(lo), 64'(last_lo));
    repeat (40) @(negedge clk);
    chk("flush_lo_later", 64'(lo), 64'd15);

    // asynchronous reset mid-CALC
    issue(EXE_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_hi = '0;
    last_lo = '0;

    // unknown commands are ignored
    issue(4'b0000, 32'd5, 32'd6, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("unknown_cmd_busy", 64'(busy), 64'd0);
    issue(4'b0011, 32'd5, 32'd0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("unknown_cmd2_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // new start accepted in the done cycle
    run_op(EXE_MULTU, 32'd6, 32'd7, 1'b0);
    run_op(EXE_DIVU, 32'd50, 32'd8, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   c;
      logic [S-1:0] a, b;
      c = codes[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_op(c, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle combinational ALU.
- Takes a command on the same EXE_CMD bus the ALU decodes and executes the operations the ALU cannot do in one cycle: MULT, MULTU, DIV, DIVU.
- Uses a start/busy/done handshake; the hazard unit stalls the pipeline on busy.
- Results go to the HI/LO register pair.

Parameters:
- SIZE, 32, operand and result-half width.
- COM_SIZE, 4, EXE_CMD width; same value as the ALU's.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort from the pipeline flush logic
- EXE_CMD  input  COM_SIZE  operation select, sampled with start
- val1  input  SIZE  multiplicand / dividend
- val2  input  SIZE  multiplier / divisor
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- hi  output  SIZE  product upper half / remainder
- lo  output  SIZE  product lower half / quotient
- div_by_zero  output  1  qualifies the current done; cleared on the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, div_by_zero, hi, lo, counter and all datapath registers go to 0.
- Reset mid-operation: the operation is lost and no done is issued.
- States: IDLE, CALC, FIX.
- IDLE accept:
  - Accept when start=1 and EXE_CMD is one of EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU.
  - Any other code with start=1 is ignored: stay IDLE, no done.
  - On accept, capture the operand magnitudes. For signed ops take two's-complement absolute values; for unsigned ops take raw values.
  - Also on accept: record result signs, clear counter and div_by_zero.
  - Next state is CALC, or FIX directly when the op is DIV/DIVU and val2=0.
- CALC, exactly SIZE cycles, one bit per cycle:
  - Multiply: radix-2 shift-add into a 2*SIZE accumulator.
  - Divide: restoring shift-subtract producing an unsigned quotient and remainder.
  - When counter = SIZE-1, next state is FIX.
- FIX, one cycle:
  - Apply signs. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Register hi/lo and set done=1 for the following cycle; next state is IDLE.
- Latency:
  - start sampled at edge k.
  - busy=1 for cycles k+1 .. k+SIZE+1.
  - done=1 and busy=0 in cycle k+SIZE+2.
  - A new start may be sampled in that same done cycle.
- Divide by zero: hi=val1 (raw), lo={SIZE{1'b1}}, div_by_zero=1 with done. Latency is 2 cycles (busy for 1).
- Signed overflow (val1 = most-negative value, val2 = -1): lo = most-negative value, hi=0. The magnitude algorithm produces this with no special case.
- hi/lo hold their value until the next done; they are never partially updated.
- start while busy is ignored; the requester must hold start until busy is seen.
- flush=1:
  - From any state, go to IDLE next cycle with no done.
  - hi, lo and div_by_zero are unchanged.
  - flush has priority over start and over completion in FIX.
- Widths: the multiply accumulator is 2*SIZE bits. Divide remainder arithmetic is SIZE+1 bits so the subtract borrow is visible. The counter is $clog2(SIZE) bits.

Decomposition:
- defines.v gains EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU. Their codes are allocated there, must differ from every existing EXE_* code, and must fall in the ALU's default branch.
- State encodings are local localparams.
- No sub-module required. The conditional two's-complement negate is used three times and may be a small local function.

Test Plan:
- MULTU val1=32'hFFFFFFFF, val2=32'h2 → after SIZE+2 cycles done=1, hi=32'h1, lo=32'hFFFFFFFE, busy high exactly 33 cycles.
- MULT val1=-7 (32'hFFFFFFF9), val2=6 → hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- DIV val1=-7, val2=2 → lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU val1=100, val2=7 → lo=14, hi=2.
- DIVU val2=0, val1=32'h1234 → done on the 2nd cycle after start, div_by_zero=1, hi=32'h1234, lo=32'hFFFFFFFF. The next accepted start clears div_by_zero.
- DIV val1=32'h80000000, val2=32'hFFFFFFFF → lo=32'h80000000, hi=0, div_by_zero=0.
- Control interactions:
  - start raised again mid-CALC is ignored.
  - flush at cycle 10 of CALC → IDLE next cycle, no done, hi/lo keep the previous result.
  - rst=0 mid-CALC asynchronously zeroes busy/hi/lo.
  - An unknown EXE_CMD with start leaves busy=0.
